// File: rtl/fraction_pkg.sv
// Shared definitions for the fraction divider: default precision, Q16 saturation
// values, divider state encoding and the latencies benches can rely on.
package fraction_pkg;

  localparam int DIVISOR_BITS_DEF = 7;

  localparam logic [15:0] Q16_POS_SAT = 16'h7FFF;
  localparam logic [15:0] Q16_NEG_SAT = 16'h8000;

  localparam int LAT_NORMAL = 17;
  localparam int LAT_EARLY  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_FINISH = 2'd3
  } div_state_e;

endpackage

// File: rtl/fraction_divide.sv
// Sequential restoring divider: q = trunc(num * 2^DIVISOR_BITS / den) as signed Q16,
// one quotient bit per clock, with saturation and divide-by-zero flags.
`default_nettype none

module fraction_divide
  import fraction_pkg::*;
#(
  parameter int DIVISOR_BITS = DIVISOR_BITS_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_numerator,
  input  logic [15:0] i_denominator,
  output logic [15:0] o_quotient,
  output logic        o_done,
  output logic        o_overflow,
  output logic        o_div_zero
);

  localparam int REM_W = 33 + DIVISOR_BITS;

  div_state_e       r_state;
  logic [31:0]      r_num;
  logic [15:0]      r_den;
  logic             r_sign;
  logic [REM_W-1:0] r_rem;
  logic [14:0]      r_q;
  logic [3:0]       r_cnt;
  logic             r_ov_pend;
  logic             r_dz_pend;
  logic [15:0]      r_quotient;
  logic             r_done;
  logic             r_overflow;
  logic             r_div_zero;

  logic [32:0]      w_mag;
  logic [32:0]      w_ovf_lim;
  logic [REM_W-1:0] w_den_sh;
  logic             w_ge;
  logic [15:0]      w_signed_q;
  logic [15:0]      w_sat;

  // 33-bit magnitude so that -2^31 negates without wrapping
  assign w_mag      = r_num[31] ? (33'd0 - {1'b1, r_num}) : {1'b0, r_num};
  assign w_ovf_lim  = 33'(r_den) << (15 - DIVISOR_BITS);
  assign w_den_sh   = REM_W'(r_den) << r_cnt;
  assign w_ge       = (r_rem >= w_den_sh);
  assign w_signed_q = r_sign ? (16'd0 - {1'b0, r_q}) : {1'b0, r_q};
  assign w_sat      = r_sign ? Q16_NEG_SAT : Q16_POS_SAT;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_num      <= '0;
      r_den      <= '0;
      r_sign     <= 1'b0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_ov_pend  <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_quotient <= '0;
      r_done     <= 1'b1;
      r_overflow <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_num      <= i_numerator;
            r_den      <= i_denominator;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_sign <= r_num[31];
          r_rem  <= REM_W'(w_mag) << DIVISOR_BITS;
          r_q    <= '0;
          // Early exits wait one extra clock in FINISH to keep a fixed 3-clock latency
          if (r_den == 16'd0) begin
            r_dz_pend <= 1'b1;
            r_ov_pend <= 1'b0;
            r_cnt     <= 4'd1;
            r_state   <= ST_FINISH;
          end else if (w_mag >= w_ovf_lim) begin
            r_dz_pend <= 1'b0;
            r_ov_pend <= 1'b1;
            r_cnt     <= 4'd1;
            r_state   <= ST_FINISH;
          end else begin
            r_dz_pend <= 1'b0;
            r_ov_pend <= 1'b0;
            r_cnt     <= 4'd14;
            r_state   <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (w_ge) begin
            r_rem <= r_rem - w_den_sh;
          end
          r_q <= {r_q[13:0], w_ge};
          if (r_cnt == 4'd0) begin
            r_state <= ST_FINISH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_FINISH: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_quotient <= (r_ov_pend || r_dz_pend) ? w_sat : w_signed_q;
            r_overflow <= r_ov_pend;
            r_div_zero <= r_dz_pend;
            r_done     <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_quotient = r_quotient;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_fraction_divide.sv
// Scoreboard bench for fraction_divide: reference results from 64-bit arithmetic.
`default_nettype none

module tb_fraction_divide;
  import fraction_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num = '0;
  logic [15:0] den = '0;
  logic [15:0] quotient;
  logic        done;
  logic        overflow;
  logic        div_zero;

  typedef struct {
    logic [15:0] q;
    logic        ov;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_q = 16'h0;

  fraction_divide #(.DIVISOR_BITS(7)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_numerator  (num),
    .i_denominator(den),
    .o_quotient   (quotient),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic signed [31:0] n, input logic [15:0] d);
    exp_t   e;
    longint mag;
    longint qm;
    mag = (n < 0) ? -longint'(n) : longint'(n);
    e.ov = 1'b0;
    e.dz = 1'b0;
    if (d == 16'd0) begin
      e.dz  = 1'b1;
      e.q   = (n < 0) ? 16'h8000 : 16'h7FFF;
      e.lat = 3;
    end else begin
      qm = (mag * 128) / longint'(d);
      if (qm >= 32768) begin
        e.ov  = 1'b1;
        e.q   = (n < 0) ? 16'h8000 : 16'h7FFF;
        e.lat = 3;
      end else begin
        e.q   = (n < 0) ? 16'(-qm) : 16'(qm);
        e.lat = 17;
      end
    end
    return e;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One full transaction: accept, confirm busy/held quotient, then score the result.
  task automatic run_div(input logic [31:0] n, input logic [15:0] d, input string name);
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1;
    num   = n;
    den   = d;
    sb.push_back(model(n, d));
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || overflow !== 1'b0 || div_zero !== 1'b0 || quotient !== last_q) begin
      miscompares++;
      $display("FAIL %s busy: done=%b ov=%b dz=%b q=%h, required done=0 ov=0 dz=0 q=%h",
               name, done, overflow, div_zero, quotient, last_q);
    end
    wait_done(cyc);
    e = sb.pop_front();
    last_q = e.q;
    vectors++;
    if (quotient !== e.q || overflow !== e.ov || div_zero !== e.dz || cyc != e.lat) begin
      miscompares++;
      $display("FAIL %s: q=%h ov=%b dz=%b lat=%0d, required q=%h ov=%b dz=%b lat=%0d",
               name, quotient, overflow, div_zero, cyc, e.q, e.ov, e.dz, e.lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || quotient !== 16'h0 || overflow !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: done=%b q=%h ov=%b dz=%b, required done=1 q=0000 ov=0 dz=0",
               done, quotient, overflow, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_q = 16'h0;
  endtask

  task automatic test_normal();
    run_div(32'd64, 16'd128, "half");
    run_div(-32'sd300, 16'd7, "neg_trunc");
    run_div(32'd351, 16'd1000, "round_trip");
    run_div(32'd255, 16'd1, "max_no_ovf");
    run_div(32'd0, 16'd5, "zero_num");
    run_div(-32'sd1, 16'd3, "small_neg");
    run_div(32'd123456, 16'd65535, "big_den");
  endtask

  task automatic test_saturate();
    run_div(32'd100000, 16'd1, "ovf_pos");
    run_div(-32'sd100000, 16'd1, "ovf_neg");
    run_div(-32'sd256, 16'd1, "ovf_neg_32768");
    run_div(32'd256, 16'd1, "ovf_pos_32768");
    run_div(32'h8000_0000, 16'd1, "ovf_min_int");
  endtask

  task automatic test_div_zero();
    run_div(32'd500, 16'd0, "dz_pos");
    run_div(-32'sd500, 16'd0, "dz_neg");
    run_div(32'd0, 16'd0, "dz_zero");
    run_div(32'd1000, 16'd3, "flags_cleared");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    num   = 32'd1000;
    den   = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b1 || quotient !== 16'h0 || overflow !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: done=%b q=%h ov=%b dz=%b, required done=1 q=0000 ov=0 dz=0",
               done, quotient, overflow, div_zero);
    end
    last_q = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || quotient !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_idle: done=%b q=%h, required done=1 q=0000", done, quotient);
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1;
    num   = 32'd64;
    den   = 16'd128;
    sb.push_back(model(32'd64, 16'd128));
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 5) begin
        start = 1'b1;
        num   = 32'd999;
        den   = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    last_q = e.q;
    vectors++;
    if (quotient !== e.q || overflow !== e.ov || cyc != e.lat) begin
      miscompares++;
      $display("FAIL start_ignored: q=%h ov=%b lat=%0d, required q=%h ov=%b lat=%0d",
               quotient, overflow, cyc, e.q, e.ov, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1;
    num   = -32'sd300;
    den   = 16'd7;
    sb.push_back(model(-32'sd300, 16'd7));
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 16) begin
        start = 1'b1;
        num   = 32'd351;
        den   = 16'd1000;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    last_q = e.q;
    vectors++;
    if (quotient !== e.q || cyc != e.lat) begin
      miscompares++;
      $display("FAIL b2b_first: q=%h lat=%0d, required q=%h lat=%0d", quotient, cyc, e.q, e.lat);
    end
    sb.push_back(model(32'd351, 16'd1000));
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: done=%b, required done=0", done);
    end
    wait_done(cyc);
    e = sb.pop_front();
    last_q = e.q;
    vectors++;
    if (quotient !== e.q || overflow !== e.ov || cyc != e.lat) begin
      miscompares++;
      $display("FAIL b2b_second: q=%h ov=%b lat=%0d, required q=%h ov=%b lat=%0d",
               quotient, overflow, cyc, e.q, e.ov, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_div_zero();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
